// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory responder: DMType access codes and FSM states.
package dm_pkg;

    localparam logic [2:0] dm_word              = 3'b000;
    localparam logic [2:0] dm_halfword          = 3'b001;
    localparam logic [2:0] dm_halfword_unsigned = 3'b010;
    localparam logic [2:0] dm_byte              = 3'b011;
    localparam logic [2:0] dm_byte_unsigned     = 3'b100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/dmem_lane.sv
// Combinational lane steering: store byte-enables/replicated data and load select/extend,
// plus the misaligned/illegal check for one access.
module dmem_lane
    import dm_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  dmtype,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rext,
    output logic        err
);

    logic        illegal;
    logic        misal;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = 8'(rword >> {off, 3'b000});
    assign half_v = off[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        be      = 4'h0;
        wword   = 32'h0;
        rext    = 32'h0;
        // Unsigned variants only make sense for loads.
        illegal = (dmtype > dm_byte_unsigned) ||
                  (we && (dmtype == dm_halfword_unsigned || dmtype == dm_byte_unsigned));
        case (dmtype)
            dm_word:                           misal = (off != 2'b00);
            dm_halfword, dm_halfword_unsigned: misal = off[0];
            default:                           misal = 1'b0;
        endcase
        err = illegal | misal;

        if (!err) begin
            case (dmtype)
                dm_word: begin
                    be    = 4'hF;
                    wword = wdata;
                    rext  = rword;
                end
                dm_halfword: begin
                    be    = off[1] ? 4'hC : 4'h3;
                    wword = {2{wdata[15:0]}};
                    rext  = {{16{half_v[15]}}, half_v};
                end
                dm_halfword_unsigned: rext = {16'h0, half_v};
                dm_byte: begin
                    be    = 4'h1 << off;
                    wword = {4{wdata[7:0]}};
                    rext  = {{24{byte_v[7]}}, byte_v};
                end
                dm_byte_unsigned: rext = {24'h0, byte_v};
                default: ;
            endcase
            if (we) rext = 32'h0;
            else    be   = 4'h0;
        end
    end

endmodule

// File: rtl/dmem_unit.sv
// Multi-cycle data-memory responder: IDLE -> BUSY -> DONE handshake around a word array
// with byte/halfword lane steering and load extension.
module dmem_unit
    import dm_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  dmtype,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err
);

    logic [1:0]    state_q, state_d;
    logic          we_q;
    logic [2:0]    dmtype_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wword;
    logic [31:0]   rext;
    logic          lane_err;
    logic          unused_addr;

    // Bits above the array span wrap; they are deliberately dropped.
    assign unused_addr = ^addr[31:AW+2];
    assign idx         = addr_q[AW+1:2];

    dmem_lane u_lane (
        .we     (we_q),
        .dmtype (dmtype_q),
        .off    (addr_q[1:0]),
        .wdata  (wdata_q),
        .rword  (mem[idx]),
        .be     (be),
        .wword  (wword),
        .rext   (rext),
        .err    (lane_err)
    );

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = req ? ST_BUSY : ST_IDLE;
            ST_BUSY: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_BUSY) begin
                rdata_q <= rext;
                err_q   <= lane_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && req) begin
            we_q     <= we;
            dmtype_q <= dmtype;
            addr_q   <= addr[AW+1:0];
            wdata_q  <= wdata;
        end
    end

    // A reset during BUSY forces IDLE asynchronously, so an abandoned store never lands here.
    always_ff @(posedge clk) begin
        if (state_q == ST_BUSY) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dmem_unit.sv
// Directed bench for dmem_unit: handshake timing, lane steering, extension, error and reset cases.
module tb_dmem_unit;

    logic        clk;
    logic        rstn;
    logic        req;
    logic        we;
    logic [2:0]  dmtype;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    int checks;
    int failures;

    dmem_unit dut (
        .clk    (clk),
        .rstn   (rstn),
        .req    (req),
        .we     (we),
        .dmtype (dmtype),
        .addr   (addr),
        .wdata  (wdata),
        .ready  (ready),
        .done   (done),
        .rdata  (rdata),
        .err    (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with the unit idle; returns just after the edge that ends DONE.
    task automatic txn(input string tag, input logic w, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
        chk({tag, "_ready_before"}, {31'b0, ready}, 32'd1);
        req = 1'b1; we = w; dmtype = t; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        chk({tag, "_busy_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_busy_ready"}, {31'b0, ready}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_rdata"}, rdata, exp_rd);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, {31'b0, done}, 32'd0);
        chk({tag, "_rdata_hold"}, rdata, exp_rd);
    endtask

    int cnt;

    initial begin
        checks = 0; failures = 0;
        rstn = 1'b0; req = 1'b0; we = 1'b0; dmtype = 3'b000; addr = 32'h0; wdata = 32'h0;
        #22;
        rstn = 1'b1;
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_done",  {31'b0, done},  32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err",   {31'b0, err},   32'd0);
        @(posedge clk); #1;

        txn("st_word",    1'b1, 3'b000, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        txn("ld_b13_s",   1'b0, 3'b011, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        txn("ld_b13_u",   1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
        txn("ld_h10_s",   1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
        txn("st_w_mis",   1'b1, 3'b000, 32'h12, 32'h11111111, 32'h0, 1'b1);
        txn("ld_w_after", 1'b0, 3'b000, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        txn("ld_h13_mis", 1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1);
        txn("st_b11",     1'b1, 3'b011, 32'h11, 32'hFFFFFF5A, 32'h0, 1'b0);
        txn("ld_w_b11",   1'b0, 3'b000, 32'h10, 32'h0, 32'hDEAD5AEF, 1'b0);
        txn("ld_ill_101", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0, 1'b1);
        txn("st_ill_100", 1'b1, 3'b100, 32'h10, 32'h000000FF, 32'h0, 1'b1);
        txn("ld_w_ill",   1'b0, 3'b000, 32'h10, 32'h0, 32'hDEAD5AEF, 1'b0);
        txn("st_h12",     1'b1, 3'b001, 32'h12, 32'hA5A5C3C3, 32'h0, 1'b0);
        txn("ld_w_h12",   1'b0, 3'b000, 32'h10, 32'h0, 32'hC3C35AEF, 1'b0);
        txn("ld_h12_u",   1'b0, 3'b010, 32'h12, 32'h0, 32'h0000C3C3, 1'b0);
        txn("ld_h12_s",   1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFC3C3, 1'b0);
        txn("ld_b12_u",   1'b0, 3'b100, 32'h12, 32'h0, 32'h000000C3, 1'b0);
        txn("ld_wrap",    1'b0, 3'b000, 32'h00001010, 32'h0, 32'hC3C35AEF, 1'b0);

        // Request held through BUSY and DONE must produce a single completion.
        cnt = 0;
        req = 1'b1; we = 1'b0; dmtype = 3'b000; addr = 32'h10;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        chk("held_req_dones", cnt, 32'd1);

        // Reset during BUSY abandons the store.
        txn("st_w20", 1'b1, 3'b000, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
        txn("ld_w20", 1'b0, 3'b000, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
        req = 1'b1; we = 1'b1; dmtype = 3'b000; addr = 32'h20; wdata = 32'h12345678;
        @(posedge clk); #1;
        req = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("rstbusy_ready", {31'b0, ready}, 32'd1);
        chk("rstbusy_rdata", rdata, 32'h0);
        #3 rstn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        chk("rstbusy_no_done", cnt, 32'd0);
        txn("ld_w20_kept", 1'b0, 3'b000, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

        // Reset during DONE drops done at once.
        req = 1'b1; we = 1'b0; dmtype = 3'b011; addr = 32'h23;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        chk("rstdone_pre", {31'b0, done}, 32'd1);
        chk("rstdone_pre_rdata", rdata, 32'hFFFFFFCA);
        rstn = 1'b0;
        #1;
        chk("rstdone_done", {31'b0, done}, 32'd0);
        chk("rstdone_rdata", rdata, 32'h0);
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        chk("rstdone_ready", {31'b0, ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
